// File: rtl/eq_fir_sequencer.sv
// Tap sequencer and signed accumulator for one equalizer FIR section, driving an external
// unsigned 24x16 multiplier. Optional output clamping is built when EQ_FIR_SAT_EN is defined.
module eq_fir_sequencer #(
    parameter int TAPS = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [23:0] i_sample,
    input  logic        i_sample_valid,
    output logic        o_in_ready,
    input  logic        i_coef_we,
    input  logic [4:0]  i_coef_addr,
    input  logic [15:0] i_coef_data,
    output logic [23:0] o_mult_sample,
    output logic [15:0] o_mult_coefficient,
    output logic        o_mult_start,
    input  logic [39:0] i_mult_product,
    input  logic        i_mult_ready,
    output logic [23:0] o_sample,
    output logic        o_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [4:0] LAST_TAP = 5'(TAPS - 1);

    state_t             state_q, state_d;
    logic [23:0]        delay_q [TAPS];
    logic [23:0]        delay_d [TAPS];
    logic [15:0]        coef_q  [TAPS];
    logic [15:0]        coef_d  [TAPS];
    logic signed [47:0] acc_q, acc_d;
    logic [4:0]         tap_q, tap_d;
    logic               first_q, first_d;
    logic               neg_q, neg_d;
    logic [23:0]        msamp_q, msamp_d;
    logic [15:0]        mcoef_q, mcoef_d;
    logic [23:0]        out_q, out_d;
    logic               valid_q, valid_d;
    logic [23:0]        sel_sample_s;
    logic [15:0]        sel_coef_s;
    logic signed [47:0] prod_s;

    function automatic logic [23:0] mag24(input logic [23:0] v);
        return v[23] ? (~v + 24'd1) : v;
    endfunction

    function automatic logic [15:0] mag16(input logic [15:0] v);
        return v[15] ? (~v + 16'd1) : v;
    endfunction

`ifdef EQ_FIR_SAT_EN
    logic signed [47:0] y_s;
    assign y_s = (acc_q + 48'sd16384) >>> 15;
`endif

    assign prod_s             = {8'd0, i_mult_product};
    assign o_in_ready         = (state_q == S_IDLE);
    assign o_mult_start       = (state_q == S_ISSUE) && i_mult_ready;
    assign o_mult_sample      = msamp_q;
    assign o_mult_coefficient = mcoef_q;
    assign o_sample           = out_q;
    assign o_valid            = valid_q;

    // Next-state, datapath and operand-capture logic
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        coef_d  = coef_q;
        acc_d   = acc_q;
        tap_d   = tap_q;
        first_d = first_q;
        neg_d   = neg_q;
        msamp_d = msamp_q;
        mcoef_d = mcoef_q;
        out_d   = out_q;
        valid_d = 1'b0;
        sel_sample_s = 24'd0;
        sel_coef_s   = 16'd0;

        for (int k = 0; k < TAPS; k++) begin
            if (i_coef_we && (i_coef_addr == 5'(k))) begin
                coef_d[k] = i_coef_data;
            end else begin
                coef_d[k] = coef_q[k];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_sample_valid) begin
                    delay_d[0] = i_sample;
                    for (int k = 1; k < TAPS; k++) begin
                        delay_d[k] = delay_q[k-1];
                    end
                    acc_d   = 48'sd0;
                    tap_d   = 5'd0;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (i_mult_ready) begin
                    first_d = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                // The multiplier still shows ready in the cycle right after start.
                if (first_q) begin
                    first_d = 1'b0;
                end else if (i_mult_ready) begin
                    acc_d = neg_q ? (acc_q - prod_s) : (acc_q + prod_s);
                    if (tap_q == LAST_TAP) begin
                        state_d = S_DONE;
                    end else begin
                        tap_d   = tap_q + 5'd1;
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
`ifdef EQ_FIR_SAT_EN
                if (y_s > 48'sd8388607) begin
                    out_d = 24'h7FFFFF;
                end else if (y_s < -48'sd8388608) begin
                    out_d = 24'h800000;
                end else begin
                    out_d = y_s[23:0];
                end
`else
                out_d = 24'((acc_q + 48'sd16384) >>> 15);
`endif
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int k = 0; k < TAPS; k++) begin
            sel_sample_s = (tap_d == 5'(k)) ? delay_d[k] : sel_sample_s;
            sel_coef_s   = (tap_d == 5'(k)) ? coef_d[k]  : sel_coef_s;
        end

        // Operands track the upcoming tap while in ISSUE, then freeze through WAIT.
        if (state_d == S_ISSUE) begin
            msamp_d = mag24(sel_sample_s);
            mcoef_d = mag16(sel_coef_s);
            neg_d   = sel_sample_s[23] ^ sel_coef_s[15];
        end else begin
            msamp_d = msamp_q;
            mcoef_d = mcoef_q;
            neg_d   = neg_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            for (int k = 0; k < TAPS; k++) begin
                delay_q[k] <= 24'd0;
                coef_q[k]  <= 16'd0;
            end
            acc_q   <= 48'sd0;
            tap_q   <= 5'd0;
            first_q <= 1'b0;
            neg_q   <= 1'b0;
            msamp_q <= 24'd0;
            mcoef_q <= 16'd0;
            out_q   <= 24'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            coef_q  <= coef_d;
            acc_q   <= acc_d;
            tap_q   <= tap_d;
            first_q <= first_d;
            neg_q   <= neg_d;
            msamp_q <= msamp_d;
            mcoef_q <= mcoef_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_eq_fir_sequencer.sv
// Self-checking bench for eq_fir_sequencer: behavioural multiplier plus a sum-of-products reference.
module tb_eq_fir_sequencer;
    localparam int TAPS = 8;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [23:0] i_sample;
    logic        i_sample_valid;
    logic        o_in_ready;
    logic        i_coef_we;
    logic [4:0]  i_coef_addr;
    logic [15:0] i_coef_data;
    logic [23:0] o_mult_sample;
    logic [15:0] o_mult_coefficient;
    logic        o_mult_start;
    logic [39:0] i_mult_product;
    logic        i_mult_ready;
    logic [23:0] o_sample;
    logic        o_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int bad_start = 0;

    longint hist [TAPS];
    longint cm   [TAPS];

    always #5 i_clk = ~i_clk;

    eq_fir_sequencer #(.TAPS(TAPS)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_sample(i_sample), .i_sample_valid(i_sample_valid), .o_in_ready(o_in_ready),
        .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
        .o_mult_sample(o_mult_sample), .o_mult_coefficient(o_mult_coefficient),
        .o_mult_start(o_mult_start), .i_mult_product(i_mult_product), .i_mult_ready(i_mult_ready),
        .o_sample(o_sample), .o_valid(o_valid)
    );

    // 16-cycle multiplier whose ready drops one cycle after start; not touched by i_rst
    logic [4:0]  m_cnt   = 5'd0;
    logic        m_ready = 1'b1;
    logic [39:0] m_prod  = 40'd0;
    always @(posedge i_clk) begin
        if (o_mult_start === 1'b1) begin
            m_cnt  <= 5'd16;
            m_prod <= {16'd0, o_mult_sample} * {24'd0, o_mult_coefficient};
        end else if (m_cnt != 5'd0) begin
            m_cnt <= m_cnt - 5'd1;
        end
        m_ready <= (m_cnt <= 5'd1);
    end
    assign i_mult_ready   = m_ready;
    assign i_mult_product = m_prod;

    always @(negedge i_clk) begin
        if (o_mult_start === 1'b1) begin
            n_start++;
            if (i_mult_ready !== 1'b1) bad_start++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] golden();
        longint acc;
        longint y;
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += hist[k] * cm[k];
        y = (acc + 64'sd16384) >>> 15;
`ifdef EQ_FIR_SAT_EN
        if (y > 64'sd8388607) y = 64'sd8388607;
        else if (y < -64'sd8388608) y = -64'sd8388608;
`endif
        return y[23:0];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < TAPS; k++) begin
            hist[k] = 0;
            cm[k]   = 0;
        end
    endtask

    task automatic model_push(input logic [23:0] s);
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'($signed(s));
    endtask

    task automatic write_coef(input logic [4:0] addr, input logic [15:0] data);
        i_coef_we   = 1'b1;
        i_coef_addr = addr;
        i_coef_data = data;
        @(posedge i_clk);
        if (int'(addr) < TAPS) cm[addr] = longint'($signed(data));
        @(negedge i_clk);
        i_coef_we = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where o_valid is seen
    task automatic send(input logic [23:0] s, input bit chk_lat, input bit junk);
        int cyc;
        int base;
        logic [23:0] exp;
        cyc = 0;
        while (o_in_ready !== 1'b1 && cyc < 400) begin
            @(negedge i_clk);
            cyc++;
        end
        check("in_ready_idle", {63'd0, o_in_ready}, 64'd1);
        i_sample       = s;
        i_sample_valid = 1'b1;
        @(posedge i_clk);
        model_push(s);
        exp  = golden();
        base = n_start;
        @(negedge i_clk);
        i_sample_valid = 1'b0;
        check("valid_low_after_accept", {63'd0, o_valid}, 64'd0);
        check("in_ready_busy", {63'd0, o_in_ready}, 64'd0);
        cyc = 0;
        while (o_valid !== 1'b1 && cyc < 400) begin
            if (junk && cyc < 100) begin
                i_sample_valid = 1'($urandom_range(0, 1));
                i_sample       = 24'($urandom);
            end else begin
                i_sample_valid = 1'b0;
            end
            @(negedge i_clk);
            cyc++;
        end
        i_sample_valid = 1'b0;
        check("o_valid", {63'd0, o_valid}, 64'd1);
        check("o_sample", {40'd0, o_sample}, {40'd0, exp});
        check("in_ready_with_valid", {63'd0, o_in_ready}, 64'd1);
        if (chk_lat) begin
            check("latency", 64'(cyc), 64'(18 * TAPS + 1));
            check("start_pulses", 64'(n_start - base), 64'(TAPS));
        end else begin
            check("latency_stalled", {63'd0, (cyc > 18 * TAPS + 1)}, 64'd1);
        end
    endtask

    initial begin
        logic [23:0] rs;
        i_rst = 1'b1;
        i_sample = 24'd0;
        i_sample_valid = 1'b0;
        i_coef_we = 1'b0;
        i_coef_addr = 5'd0;
        i_coef_data = 16'd0;
        model_clear();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        check("rst_valid", {63'd0, o_valid}, 64'd0);
        check("rst_sample", {40'd0, o_sample}, 64'd0);
        check("rst_in_ready", {63'd0, o_in_ready}, 64'd1);
        check("rst_start", {63'd0, o_mult_start}, 64'd0);
        check("rst_msample", {40'd0, o_mult_sample}, 64'd0);
        check("rst_mcoef", {48'd0, o_mult_coefficient}, 64'd0);

        // Impulse response through a ramp of coefficients
        for (int k = 0; k < TAPS; k++) write_coef(5'(k), 16'(k * 1024));
        send(24'h7FFFFF, 1'b1, 1'b0);
        check("impulse_tap0", {40'd0, o_sample}, 64'd0);
        for (int k = 1; k < TAPS; k++) send(24'd0, 1'b1, 1'b0);

        // Sign handling and full-scale negative
        for (int k = 0; k < TAPS; k++) write_coef(5'(k), (k == 0) ? 16'h8000 : 16'h0000);
        send(24'hFFF000, 1'b1, 1'b0);
        check("sign_neg4096", {40'd0, o_sample}, 64'h1000);
        send(24'h800000, 1'b1, 1'b0);
`ifdef EQ_FIR_SAT_EN
        check("sign_fullscale", {40'd0, o_sample}, 64'h7FFFFF);
`else
        check("sign_fullscale", {40'd0, o_sample}, 64'h800000);
`endif

        // Round half up
        write_coef(5'd0, 16'h0001);
        send(24'd16384, 1'b1, 1'b0);
        check("round_pos_half", {40'd0, o_sample}, 64'd1);
        send(24'hFFC000, 1'b1, 1'b0);
        check("round_neg_half", {40'd0, o_sample}, 64'd0);

        // Accumulated overflow
        for (int k = 0; k < TAPS; k++) write_coef(5'(k), 16'h7FFF);
        for (int k = 0; k < TAPS; k++) send(24'h7FFFFF, 1'b1, 1'b0);

        // Random coefficients and samples, out-of-range writes, junk valid while busy
        for (int k = 0; k < TAPS; k++) write_coef(5'(k), 16'($urandom));
        for (int k = TAPS; k < 32; k += 5) write_coef(5'(k), 16'($urandom));
        for (int n = 0; n < 10; n++) send(24'($urandom), 1'b1, 1'b1);

        // Reset while the multiplier is busy in WAIT
        rs = 24'($urandom);
        i_sample = rs;
        i_sample_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_sample_valid = 1'b0;
        repeat (6) @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        model_clear();
        check("rst_mid_valid", {63'd0, o_valid}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            write_coef(5'(k), 16'($urandom));
            check("rst_mid_no_valid", {63'd0, o_valid}, 64'd0);
        end
        send(24'($urandom), 1'b0, 1'b0);
        send(24'($urandom), 1'b1, 1'b0);

        check("start_needs_ready", 64'(bad_start), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/eq_fir_sequencer.md
# eq_fir_sequencer

Tap sequencer and accumulator for one equalizer FIR section. Holds the sample delay line and the coefficient bank. For each tap it drives one product through the external 24x16 unsigned shift-add multiplier unit, then accumulates the signed results. It rounds and optionally saturates the sum back to a 24-bit output sample. It sits between the sample source and the next EQ section, directly upstream of the multiplier, which it feeds and whose product it consumes.

## Interface

- TAPS, 8, number of filter taps (2..32).
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_sample  in  24  input sample, two's complement.
- i_sample_valid  in  1  sample present; accepted only when o_in_ready=1.
- o_in_ready  out  1  high in IDLE only.
- i_coef_we  in  1  coefficient write strobe.
- i_coef_addr  in  5  tap index; writes with addr>=TAPS are ignored.
- i_coef_data  in  16  coefficient, two's complement Q1.15.
- o_mult_sample  out  24  magnitude of the current delay-line sample.
- o_mult_coefficient  out  16  magnitude of the current coefficient.
- o_mult_start  out  1  start pulse to the multiplier.
- i_mult_product  in  40  unsigned magnitude product.
- i_mult_ready  in  1  multiplier idle / product valid.
- o_sample  out  24  filtered sample, two's complement.
- o_valid  out  1  one-cycle pulse with o_sample.

## Operation

- Reset clears delay line, coefficient bank, accumulator, tap counter, o_sample, o_valid, o_mult_* to 0. State goes to IDLE.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: when i_sample_valid=1, shift i_sample into delay line slot 0 (oldest sample drops out). Clear accumulator and tap=0, then go to ISSUE.
- ISSUE: drive operand magnitudes for tap k = delay[k] x coef[k]. Latch neg = sign(delay[k]) XOR sign(coef[k]). Assert o_mult_start only if i_mult_ready=1, then go to WAIT. Otherwise hold in ISSUE with start low.
- WAIT: the first cycle after ISSUE is always ignored, because the multiplier deasserts ready one cycle late. On i_mult_ready=1, add ±{8'b0,i_mult_product} into the 48-bit signed accumulator, subtracting when neg=1. If tap=TAPS-1, go to DONE; otherwise increment tap and go to ISSUE.
- Magnitude rules: |−2^23| = 2^23 fits in 24 bits unsigned; |−2^15| = 2^15 fits in 16 bits. The product magnitude is < 2^40, so there is no overflow before accumulation.
- DONE: compute y = (acc + 2^14) >>> 15, an arithmetic shift with round half up. Register y[23:0] (or the saturated value, see Configuration) into o_sample, pulse o_valid, and go to IDLE.
- o_mult_start is high for exactly one cycle per tap. o_mult_sample and o_mult_coefficient are held stable from ISSUE through the end of WAIT.
- Coefficient writes are accepted in any state and take effect on the next clock. Changing a tap that has not yet been issued affects the current output.

## Timing

- Let E0 be the edge that accepts the sample. With the multiplier idle, each tap takes 18 cycles: 1 ISSUE cycle plus 17 WAIT cycles for a 16-cycle multiply.
- DONE is entered at edge E0+18·TAPS. o_sample and o_valid are registered at edge E0+18·TAPS+1. For TAPS=8 this is 145 cycles.
- o_in_ready=1 in the same cycle o_valid=1. A back-to-back sample is accepted at that edge.
- Reset mid-operation: return to IDLE with no o_valid. If the multiplier is still busy, the next ISSUE waits for i_mult_ready.
- i_sample_valid outside IDLE is ignored and no sample is lost internally. The source must hold the sample until o_in_ready.

## Configuration

- EQ_FIR_SAT_EN defined: y is clamped to [−8388608, 8388607] (0x800000..0x7FFFFF) before it is registered.
- EQ_FIR_SAT_EN undefined: o_sample = y[23:0] (wraps). No saturation logic is built.

## Test plan

- Impulse: coef[k]=k·1024 for all k, sample 8388607 followed by zeros. The outputs, in order, are round((2^23−1)·k·1024/2^15), with tap 0 giving 0 first.
- Sign: coef[0]=0x8000 (−1.0), other coefs 0, sample −4096 → o_sample=4096. Sample −8388608 with saturation enabled → 8388607; without it → −8388608 (wrap).
- Rounding: coef[0]=0x0001, sample 16384 → 1 (0.5 rounds up). Sample −16384 → 0.
- Accumulated saturation: all coefs 0x7FFF, steady input 0x7FFFFF → 0x7FFFFF with saturation enabled; with it disabled, the wrapped low 24 bits.
- Handshake and latency: TAPS=8, o_valid exactly 145 cycles after acceptance. Exactly 8 o_mult_start pulses. Back-to-back sample accepted in the o_valid cycle. i_sample_valid during busy is ignored.
- Reset mid-WAIT while the multiplier is still busy: no o_valid. The next sample's first o_mult_start waits for i_mult_ready=1. The result matches the golden model.
